// File: rtl/lap_store_if.sv
// Lap store bus: lap/clear/running/timer inputs and the stored-lap outputs.
interface lap_store_if;
  logic        lap;
  logic        clr;
  logic        running;
  logic [23:0] time_in;
  logic [23:0] save1;
  logic [23:0] save2;
  logic [23:0] save3;
  logic [23:0] save4;
  logic [23:0] save5;
  logic [23:0] save6;
  logic [23:0] save7;
  logic [23:0] save8;
  logic [3:0]  lap_count;
  logic [3:0]  last_index;
  logic        full;
  logic        new_lap;

  modport master (
    output lap, clr, running, time_in,
    input  save1, save2, save3, save4, save5, save6, save7, save8,
    input  lap_count, last_index, full, new_lap
  );

  modport slave (
    input  lap, clr, running, time_in,
    output save1, save2, save3, save4, save5, save6, save7, save8,
    output lap_count, last_index, full, new_lap
  );
endinterface

// File: rtl/lap_store.sv
// Stopwatch lap memory: a press captures the running time, the following
// release commits it into one of eight slots written round-robin. With WRAP=1
// a full store overwrites the oldest slot; with WRAP=0 extra laps are dropped.
module lap_store #(
  parameter bit WRAP = 1'b1
) (
  input logic        clk,
  input logic        rst,
  lap_store_if.slave bus
);

  typedef enum logic {IDLE, ARMED} arm_t;

  arm_t        arm_state;
  logic        lap_prev;
  logic [23:0] capture;
  logic [3:0]  wr_ptr;
  logic [2:0]  wr_slot;
  logic [3:0]  lap_count;
  logic [3:0]  last_index;
  logic        new_lap;
  logic [23:0] slot [8];
  logic        press;
  logic        release_evt;
  logic        full;
  logic        accept;

  // Edge detection on the lap button and the write-permission decision.
  always_comb begin
    press       = !lap_prev && bus.lap;
    release_evt = lap_prev && !bus.lap;
    full        = (lap_count == 4'd8);
    accept      = !(full && !WRAP);
    wr_slot     = wr_ptr[2:0] - 3'd1;
  end

  // Capture on press, commit on release; clear wins over both.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arm_state  <= IDLE;
      lap_prev   <= 1'b0;
      capture    <= '0;
      wr_ptr     <= 4'd1;
      lap_count  <= '0;
      last_index <= '0;
      new_lap    <= 1'b0;
      for (int i = 0; i < 8; i++) slot[i] <= '0;
    end else begin
      lap_prev <= bus.lap;
      new_lap  <= 1'b0;
      if (bus.clr) begin
        arm_state  <= IDLE;
        capture    <= '0;
        wr_ptr     <= 4'd1;
        lap_count  <= '0;
        last_index <= '0;
        for (int i = 0; i < 8; i++) slot[i] <= '0;
      end else if (press) begin
        if (bus.running) begin
          arm_state <= ARMED;
          capture   <= bus.time_in;
        end
      end else if (release_evt && arm_state == ARMED) begin
        arm_state <= IDLE;
        if (accept) begin
          slot[wr_slot] <= capture;
          last_index    <= wr_ptr;
          wr_ptr        <= (wr_ptr == 4'd8) ? 4'd1 : wr_ptr + 4'd1;
          if (!full) lap_count <= lap_count + 4'd1;
          new_lap <= 1'b1;
        end
      end
    end
  end

  assign bus.save1      = slot[0];
  assign bus.save2      = slot[1];
  assign bus.save3      = slot[2];
  assign bus.save4      = slot[3];
  assign bus.save5      = slot[4];
  assign bus.save6      = slot[5];
  assign bus.save7      = slot[6];
  assign bus.save8      = slot[7];
  assign bus.lap_count  = lap_count;
  assign bus.last_index = last_index;
  assign bus.full       = full;
  assign bus.new_lap    = new_lap;

endmodule

// File: tb/tb_lap_store.sv
// Bench for lap_store: a WRAP=0 and a WRAP=1 instance share one stimulus
// stream; a lap-list model predicts each commit and the monitor checks it
// whenever new_lap pulses.
module tb_lap_store;

  typedef struct packed {
    logic [7:0][23:0] slots;
    logic [3:0]       cnt;
    logic [3:0]       last;
  } snap_t;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  lap_store_if w0 ();
  lap_store_if w1 ();

  lap_store #(.WRAP(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(w0));
  lap_store #(.WRAP(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(w1));

  logic [23:0] act_slot [2][8];
  logic [3:0]  act_cnt  [2];
  logic [3:0]  act_last [2];
  logic        act_full [2];
  logic        act_new  [2];

  // Reference model: index 0 models WRAP=0, index 1 models WRAP=1.
  snap_t       ms    [2];
  int          mwr   [2];
  bit          marmed[2];
  logic [23:0] mcap  [2];
  bit          mprev;
  snap_t       sb0 [$];
  snap_t       sb1 [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Gather both instances' outputs into indexable arrays.
  always_comb begin
    act_slot[0] = '{w0.save1, w0.save2, w0.save3, w0.save4, w0.save5, w0.save6, w0.save7, w0.save8};
    act_slot[1] = '{w1.save1, w1.save2, w1.save3, w1.save4, w1.save5, w1.save6, w1.save7, w1.save8};
    act_cnt[0]  = w0.lap_count;
    act_cnt[1]  = w1.lap_count;
    act_last[0] = w0.last_index;
    act_last[1] = w1.last_index;
    act_full[0] = w0.full;
    act_full[1] = w1.full;
    act_new[0]  = w0.new_lap;
    act_new[1]  = w1.new_lap;
  end

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic compareSnap(input int m, input string tag, input snap_t s);
    for (int i = 0; i < 8; i++)
      check($sformatf("%s wrap%0d save%0d", tag, m, i + 1), act_slot[m][i], s.slots[i]);
    check($sformatf("%s wrap%0d lap_count", tag, m), {20'd0, act_cnt[m]}, {20'd0, s.cnt});
    check($sformatf("%s wrap%0d last_index", tag, m), {20'd0, act_last[m]}, {20'd0, s.last});
    check($sformatf("%s wrap%0d full", tag, m), {23'd0, act_full[m]}, {23'd0, s.cnt == 4'd8});
  endtask

  task automatic modelReset();
    mprev = 1'b0;
    for (int m = 0; m < 2; m++) begin
      ms[m]     = '0;
      mwr[m]    = 0;
      marmed[m] = 1'b0;
      mcap[m]   = '0;
    end
  endtask

  // Drive one cycle of inputs, predict that edge, then move past the edge.
  task automatic applyStimulus(input bit lap_v, input bit clr_v, input bit run_v, input logic [23:0] t_v);
    bit press, rel;
    w0.lap = lap_v;  w0.clr = clr_v;  w0.running = run_v;  w0.time_in = t_v;
    w1.lap = lap_v;  w1.clr = clr_v;  w1.running = run_v;  w1.time_in = t_v;
    press = lap_v && !mprev;
    rel   = !lap_v && mprev;
    for (int m = 0; m < 2; m++) begin
      if (clr_v) begin
        ms[m] = '0;  mwr[m] = 0;  marmed[m] = 1'b0;  mcap[m] = '0;
      end else if (press) begin
        if (run_v) begin
          marmed[m] = 1'b1;
          mcap[m]   = t_v;
        end
      end else if (rel && marmed[m]) begin
        marmed[m] = 1'b0;
        if (!(ms[m].cnt == 4'd8 && m == 0)) begin
          ms[m].slots[mwr[m]] = mcap[m];
          ms[m].last = 4'(mwr[m] + 1);
          mwr[m] = (mwr[m] + 1) % 8;
          if (ms[m].cnt < 4'd8) ms[m].cnt = ms[m].cnt + 4'd1;
          if (m == 0) sb0.push_back(ms[m]);
          else        sb1.push_back(ms[m]);
        end
      end
    end
    mprev = lap_v;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    compareSnap(0, tag, ms[0]);
    compareSnap(1, tag, ms[1]);
  endtask

  task automatic doLap(input logic [23:0] v);
    applyStimulus(1'b1, 1'b0, 1'b1, v);
    applyStimulus(1'b0, 1'b0, 1'b1, 24'hABCDEF);
  endtask

  // Asynchronous reset pulse placed mid-cycle; outputs must clear at once.
  task automatic resetPulse(input string tag);
    @(negedge clk);
    #2 rst = 1'b0;
    modelReset();
    #1;
    checkOutput(tag);
    check({tag, " wrap0 new_lap"}, {23'd0, act_new[0]}, 24'd0);
    check({tag, " wrap1 new_lap"}, {23'd0, act_new[1]}, 24'd0);
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Scoreboard monitor: every new_lap pulse must match a predicted commit.
  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (act_new[m] === 1'b1) begin
        if ((m == 0 ? sb0.size() : sb1.size()) == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected new_lap wrap%0d: got 1 expected 0", m);
        end else if (m == 0) begin
          compareSnap(0, "commit", sb0.pop_front());
        end else begin
          compareSnap(1, "commit", sb1.pop_front());
        end
      end
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b0;
    w0.lap = 1'b0;  w0.clr = 1'b0;  w0.running = 1'b0;  w0.time_in = '0;
    w1.lap = 1'b0;  w1.clr = 1'b0;  w1.running = 1'b0;  w1.time_in = '0;
    modelReset();
    #2;
    checkOutput("reset");
    @(posedge clk);
    #1 rst = 1'b1;

    // Press captures 001234, release time is ignored.
    applyStimulus(1'b1, 1'b0, 1'b1, 24'h001234);
    applyStimulus(1'b0, 1'b0, 1'b1, 24'h001299);
    checkOutput("first_lap");
    check("first_lap const save1", w1.save1, 24'h001234);
    check("first_lap const count", {20'd0, w1.lap_count}, 24'd1);

    // Nine laps from an empty store.
    applyStimulus(1'b0, 1'b1, 1'b1, '0);
    for (int v = 1; v <= 9; v++) doLap(24'(v));
    checkOutput("nine_laps");
    check("wrap1 const save1", w1.save1, 24'd9);
    check("wrap1 const save2", w1.save2, 24'd2);
    check("wrap1 const last", {20'd0, w1.last_index}, 24'd1);
    check("wrap0 const save1", w0.save1, 24'd1);
    check("wrap0 const save8", w0.save8, 24'd8);
    check("wrap0 const full", {23'd0, w0.full}, 24'd1);

    // Press while stopped is ignored; running dropping while armed still commits.
    applyStimulus(1'b0, 1'b1, 1'b1, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, 24'h000555);
    applyStimulus(1'b0, 1'b0, 1'b0, 24'h000556);
    checkOutput("stopped_press");
    applyStimulus(1'b1, 1'b0, 1'b1, 24'h000777);
    applyStimulus(1'b1, 1'b0, 1'b0, 24'h000778);
    applyStimulus(1'b0, 1'b0, 1'b0, 24'h000779);
    checkOutput("run_drop");
    check("run_drop const save1", w0.save1, 24'h000777);

    // Clear coinciding with a release after three laps.
    applyStimulus(1'b0, 1'b1, 1'b1, '0);
    for (int v = 1; v <= 3; v++) doLap(24'h100 + 24'(v));
    applyStimulus(1'b1, 1'b0, 1'b1, 24'h000444);
    applyStimulus(1'b0, 1'b1, 1'b1, 24'h000445);
    checkOutput("clr_release");
    doLap(24'h000888);
    checkOutput("after_clr");
    check("after_clr const save1", w1.save1, 24'h000888);

    // Reset between press and release discards the pending lap.
    applyStimulus(1'b1, 1'b0, 1'b1, 24'h000999);
    resetPulse("mid_reset");
    applyStimulus(1'b1, 1'b0, 1'b0, 24'h000123);
    applyStimulus(1'b0, 1'b0, 1'b0, 24'h000124);
    checkOutput("post_reset");

    // Lap held through reset release with running high counts as a press.
    applyStimulus(1'b1, 1'b0, 1'b1, 24'h000321);
    resetPulse("held_reset");
    applyStimulus(1'b1, 1'b0, 1'b1, 24'h000654);
    applyStimulus(1'b0, 1'b0, 1'b1, 24'h000655);
    checkOutput("held_lap");

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), $urandom_range(0, 40) == 0,
                    $urandom_range(0, 7) != 0, 24'($urandom));
      checkOutput("random");
    end

    @(negedge clk);
    #1;
    check("pending commits wrap0", 24'(sb0.size()), 24'd0);
    check("pending commits wrap1", 24'(sb1.size()), 24'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
